// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS-subset core: six-state FSM over one shared
// ready-handshaked memory port, with a one-cycle retire strobe.
module mips_multicycle_core #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        retire_valid,
   output logic [31:0] retire_pc,
   output logic [31:0] retire_instr,
   output logic        trapped
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_TRAP
   } state_t;

   state_t state, state_n;

   logic [31:0] pc, pc_n;
   logic [31:0] ipc, ipc_n;
   logic [31:0] ir, ir_n;
   logic [31:0] a, a_n;
   logic [31:0] b, b_n;
   logic [31:0] alu_out, alu_n;
   logic [31:0] mdr, mdr_n;

   logic        req_n, we_n, ret_n, trap_n;
   logic [31:0] addr_n, wdata_n, rpc_n, rinstr_n;

   logic [31:0] regs [32];
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd;
   logic [31:0] simm, src_b, alu_res;
   logic [31:0] rs_val, rt_val, pc_br, pc_j;
   logic        is_r, is_lw, is_sw, is_beq, is_addi, is_j, legal;

   logic        go_fetch, do_retire;
   logic [31:0] fetch_pc;

   assign op    = ir[31:26];
   assign rs    = ir[25:21];
   assign rt    = ir[20:16];
   assign rd    = ir[15:11];
   assign funct = ir[5:0];
   assign simm  = {{16{ir[15]}}, ir[15:0]};

   assign rs_val = (rs == 5'd0) ? 32'd0 : regs[rs];
   assign rt_val = (rt == 5'd0) ? 32'd0 : regs[rt];
   assign pc_br  = pc + {simm[29:0], 2'b00};
   assign pc_j   = {pc[31:28], ir[25:0], 2'b00};

   always_comb begin
      is_r    = (op == 6'h00) &&
                (funct == 6'h20 || funct == 6'h22 ||
                 funct == 6'h24 || funct == 6'h25 ||
                 funct == 6'h2A);
      is_lw   = (op == 6'h23);
      is_sw   = (op == 6'h2B);
      is_beq  = (op == 6'h04);
      is_addi = (op == 6'h08);
      is_j    = (op == 6'h02);
      legal   = is_r | is_lw | is_sw | is_beq | is_addi | is_j;
   end

   always_comb begin
      src_b   = is_r ? b : simm;
      alu_res = a + src_b;
      if (is_r) begin
         case (funct)
            6'h22:   alu_res = a - b;
            6'h24:   alu_res = a & b;
            6'h25:   alu_res = a | b;
            6'h2A:   alu_res = {31'd0, $signed(a) < $signed(b)};
            default: alu_res = a + b;
         endcase
      end
   end

   always_comb begin
      state_n   = state;
      pc_n      = pc;
      ipc_n     = ipc;
      ir_n      = ir;
      a_n       = a;
      b_n       = b;
      alu_n     = alu_out;
      mdr_n     = mdr;
      req_n     = mem_req;
      we_n      = mem_we;
      addr_n    = mem_addr;
      wdata_n   = mem_wdata;
      ret_n     = 1'b0;
      rpc_n     = retire_pc;
      rinstr_n  = retire_instr;
      trap_n    = trapped;
      go_fetch  = 1'b0;
      do_retire = 1'b0;
      fetch_pc  = pc;
      rf_we     = 1'b0;
      rf_waddr  = is_r ? rd : rt;
      rf_wdata  = is_lw ? mdr : alu_out;

      case (state)
         S_FETCH: begin
            if (!mem_req) begin
               req_n  = 1'b1;
               we_n   = 1'b0;
               addr_n = pc;
            end else if (mem_ready) begin
               ir_n    = mem_rdata;
               ipc_n   = pc;
               pc_n    = pc + 32'd4;
               req_n   = 1'b0;
               state_n = S_DECODE;
            end
         end
         S_DECODE: begin
            a_n = rs_val;
            b_n = rt_val;
            if (is_j) begin
               pc_n      = pc_j;
               fetch_pc  = pc_j;
               go_fetch  = 1'b1;
               do_retire = 1'b1;
            end else if (!legal) begin
               if (TRAP_ON_ILLEGAL) begin
                  state_n = S_TRAP;
                  trap_n  = 1'b1;
               end else begin
                  go_fetch  = 1'b1;
                  do_retire = 1'b1;
               end
            end else begin
               state_n = S_EXEC;
            end
         end
         S_EXEC: begin
            alu_n = alu_res;
            if (is_beq) begin
               if (a == b) begin
                  pc_n     = pc_br;
                  fetch_pc = pc_br;
               end
               go_fetch  = 1'b1;
               do_retire = 1'b1;
            end else if (is_lw || is_sw) begin
               // alignment is resolved here so no bad address is issued
               if (alu_res[1:0] != 2'b00) begin
                  if (TRAP_ON_ILLEGAL) begin
                     state_n = S_TRAP;
                     trap_n  = 1'b1;
                  end else begin
                     go_fetch  = 1'b1;
                     do_retire = 1'b1;
                  end
               end else begin
                  state_n = S_MEM;
                  req_n   = 1'b1;
                  we_n    = is_sw;
                  addr_n  = alu_res;
                  wdata_n = b;
               end
            end else begin
               state_n = S_WB;
            end
         end
         S_MEM: begin
            if (mem_ready) begin
               if (is_sw) begin
                  go_fetch  = 1'b1;
                  do_retire = 1'b1;
               end else begin
                  mdr_n   = mem_rdata;
                  req_n   = 1'b0;
                  we_n    = 1'b0;
                  state_n = S_WB;
               end
            end
         end
         S_WB: begin
            rf_we     = 1'b1;
            go_fetch  = 1'b1;
            do_retire = 1'b1;
         end
         S_TRAP: begin
            req_n = 1'b0;
            we_n  = 1'b0;
         end
         default: begin
            state_n = S_FETCH;
         end
      endcase

      // next fetch is requested on the same edge to keep CPI minimal
      if (go_fetch) begin
         state_n = S_FETCH;
         req_n   = 1'b1;
         we_n    = 1'b0;
         addr_n  = fetch_pc;
      end
      if (do_retire) begin
         ret_n    = 1'b1;
         rpc_n    = ipc;
         rinstr_n = ir;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_FETCH;
      end else begin
         state <= state_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc           <= RESET_PC;
         ipc          <= 32'd0;
         ir           <= 32'd0;
         a            <= 32'd0;
         b            <= 32'd0;
         alu_out      <= 32'd0;
         mdr          <= 32'd0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= RESET_PC;
         mem_wdata    <= 32'd0;
         retire_valid <= 1'b0;
         retire_pc    <= 32'd0;
         retire_instr <= 32'd0;
         trapped      <= 1'b0;
      end else begin
         pc           <= pc_n;
         ipc          <= ipc_n;
         ir           <= ir_n;
         a            <= a_n;
         b            <= b_n;
         alu_out      <= alu_n;
         mdr          <= mdr_n;
         mem_req      <= req_n;
         mem_we       <= we_n;
         mem_addr     <= addr_n;
         mem_wdata    <= wdata_n;
         retire_valid <= ret_n;
         retire_pc    <= rpc_n;
         retire_instr <= rinstr_n;
         trapped      <= trap_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= 32'd0;
         end
      end else if (rf_we && rf_waddr != 5'd0) begin
         regs[rf_waddr] <= rf_wdata;
      end
   end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: wait-stated memory model,
// retire monitor, one task per scenario.
module tb_mips_multicycle_core;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        mem_req, mem_we, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        retire_valid, trapped;
   logic [31:0] retire_pc, retire_instr;

   logic        rst2_n = 1'b0;
   logic        mem_req2, mem_we2, retire_valid2, trapped2;
   logic [31:0] mem_addr2, mem_wdata2, mem_rdata2;
   logic [31:0] retire_pc2, retire_instr2;

   logic [31:0]   mem [0:1023];
   logic [31:0]   wmem [0:1023];
   logic [1023:0] wvalid;
   int            wait_n = 0;
   int            wcnt = 0;
   int            cyc = 0;
   int            passed = 0;
   int            total = 0;

   logic [31:0] q_pc[$], q_in[$], q2_pc[$], q2_in[$];
   int          q_cy[$], q2_cy[$];

   always #5 clk = ~clk;

   mips_multicycle_core #(
      .RESET_PC(32'h0), .TRAP_ON_ILLEGAL(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .retire_valid(retire_valid), .retire_pc(retire_pc),
      .retire_instr(retire_instr), .trapped(trapped)
   );

   mips_multicycle_core #(
      .RESET_PC(32'h0), .TRAP_ON_ILLEGAL(1'b0)
   ) dut_nt (
      .clk(clk), .rst_n(rst2_n),
      .mem_req(mem_req2), .mem_we(mem_we2),
      .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
      .mem_rdata(mem_rdata2), .mem_ready(1'b1),
      .retire_valid(retire_valid2), .retire_pc(retire_pc2),
      .retire_instr(retire_instr2), .trapped(trapped2)
   );

   assign mem_ready = mem_req && (wcnt >= wait_n);
   assign mem_rdata = wvalid[mem_addr[11:2]] ?
                      wmem[mem_addr[11:2]] : mem[mem_addr[11:2]];
   assign mem_rdata2 = mem[mem_addr2[11:2]];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst_n) wcnt <= 0;
      else if (mem_req && !mem_ready) wcnt <= wcnt + 1;
      else wcnt <= 0;
   end

   always @(posedge clk) begin
      if (!rst_n) begin
         wvalid <= '0;
      end else if (mem_req && mem_ready && mem_we) begin
         wvalid[mem_addr[11:2]] <= 1'b1;
         wmem[mem_addr[11:2]]   <= mem_wdata;
      end
   end

   always @(negedge clk) begin
      if (rst_n && retire_valid) begin
         q_pc.push_back(retire_pc);
         q_in.push_back(retire_instr);
         q_cy.push_back(cyc);
      end
      if (rst2_n && retire_valid2) begin
         q2_pc.push_back(retire_pc2);
         q2_in.push_back(retire_instr2);
         q2_cy.push_back(cyc);
      end
   end

   function automatic logic [31:0] enc_r(input logic [4:0] s, t, d,
                                         input logic [5:0] fn);
      return {6'h00, s, t, d, 5'h00, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] o,
                                         input logic [4:0] s, t,
                                         input logic [15:0] imm);
      return {o, s, t, imm};
   endfunction

   function automatic logic [31:0] enc_j(input logic [25:0] tgt);
      return {6'h02, tgt};
   endfunction

   task automatic start_reset();
      @(negedge clk);
      rst_n = 1'b0;
      wait_n = 0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
      repeat (2) @(negedge clk);
      q_pc.delete(); q_in.delete(); q_cy.delete();
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_ret(input int n, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         #1;
         if (q_pc.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bit seen;
      start_reset();
      total++;
      if ({mem_req, mem_we, retire_valid, trapped} !== 4'b0000)
         $display("FAIL reset_flags: got %b want 0000",
                  {mem_req, mem_we, retire_valid, trapped});
      else passed++;
      total++;
      if ({mem_addr, mem_wdata} !== 64'd0)
         $display("FAIL reset_addr_wdata: got %h %h want 0 0",
                  mem_addr, mem_wdata);
      else passed++;
      total++;
      if ({retire_pc, retire_instr} !== 64'd0)
         $display("FAIL reset_retire: got %h %h want 0 0",
                  retire_pc, retire_instr);
      else passed++;
      mem[0] = enc_j(26'd0);
      release_reset();
      seen = 1'b0;
      for (int k = 0; k < 5 && !seen; k++) begin
         @(negedge clk);
         if (mem_req) seen = 1'b1;
      end
      total++;
      if (!seen || mem_addr !== 32'd0 || mem_we !== 1'b0)
         $display("FAIL first_fetch: req %b addr %h we %b want 1 0 0",
                  seen, mem_addr, mem_we);
      else passed++;
   endtask

   task automatic test_alu_program();
      bit ok;
      logic [31:0] prog [4];
      start_reset();
      prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
      prog[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
      prog[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
      prog[3] = enc_r(5'd1, 5'd2, 5'd4, 6'h22);
      for (int i = 0; i < 4; i++) mem[i] = prog[i];
      mem[4] = enc_j(26'd4);
      release_reset();
      wait_ret(4, ok);
      total++;
      if (!ok) $display("FAIL alu_timeout: got %0d retires want 4",
                        q_pc.size());
      else passed++;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (q_pc[i] !== 32'(i * 4) || q_in[i] !== prog[i])
            $display("FAIL alu_retire%0d: got %h/%h want %h/%h", i,
                     q_pc[i], q_in[i], 32'(i * 4), prog[i]);
         else passed++;
      end
      for (int i = 1; i < 4; i++) begin
         total++;
         if (q_cy[i] - q_cy[i-1] != 4)
            $display("FAIL alu_cpi%0d: got %0d want 4", i,
                     q_cy[i] - q_cy[i-1]);
         else passed++;
      end
      total++;
      if (dut.regs[3] !== 32'd12)
         $display("FAIL add_r3: got %h want 0000000c", dut.regs[3]);
      else passed++;
      total++;
      if (dut.regs[4] !== 32'hFFFF_FFFE)
         $display("FAIL sub_r4: got %h want fffffffe", dut.regs[4]);
      else passed++;
   endtask

   task automatic test_mem_wait();
      bit ok;
      int swc, lwc, bad;
      start_reset();
      mem[0] = enc_i(6'h08, 5'd0, 5'd3, 16'd12);
      mem[1] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0040);
      mem[2] = enc_i(6'h23, 5'd0, 5'd5, 16'h0040);
      mem[3] = enc_j(26'd3);
      wait_n = 3;
      release_reset();
      swc = 0; lwc = 0; bad = 0; ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (mem_req && mem_we) begin
            swc++;
            if (mem_addr !== 32'h40 || mem_wdata !== 32'd12) bad++;
         end
         if (mem_req && !mem_we && mem_addr === 32'h40) lwc++;
         #1;
         if (q_pc.size() >= 3) begin
            ok = 1'b1;
            break;
         end
      end
      total++;
      if (!ok) $display("FAIL mem_timeout: got %0d retires want 3",
                        q_pc.size());
      else passed++;
      total++;
      if (swc != 4 || bad != 0)
         $display("FAIL sw_stable: got %0d cycles %0d bad want 4 0",
                  swc, bad);
      else passed++;
      total++;
      if (lwc != 4)
         $display("FAIL lw_req_cycles: got %0d want 4", lwc);
      else passed++;
      total++;
      if (q_cy[1] - q_cy[0] != 10)
         $display("FAIL sw_latency: got %0d want 10", q_cy[1] - q_cy[0]);
      else passed++;
      total++;
      if (q_pc[2] !== 32'h8 || q_cy[2] - q_cy[1] != 11)
         $display("FAIL lw_latency: got pc %h lat %0d want 8 11",
                  q_pc[2], q_cy[2] - q_cy[1]);
      else passed++;
      total++;
      if (wmem[16] !== 32'd12 || dut.regs[5] !== 32'd12)
         $display("FAIL lw_data: got mem %h r5 %h want c c",
                  wmem[16], dut.regs[5]);
      else passed++;
   endtask

   task automatic test_branch_jump();
      bit ok;
      logic [31:0] exp_pc [9];
      exp_pc = '{32'h0, 32'h4, 32'h8, 32'h20, 32'h2C,
                 32'h30, 32'h400, 32'h10, 32'h10};
      start_reset();
      mem[0]   = enc_i(6'h08, 5'd0, 5'd1, 16'd3);
      mem[1]   = enc_i(6'h08, 5'd0, 5'd2, 16'd3);
      mem[2]   = enc_j(26'h8);
      mem[8]   = enc_i(6'h04, 5'd1, 5'd2, 16'd2);
      mem[11]  = enc_i(6'h04, 5'd1, 5'd0, 16'd5);
      mem[12]  = enc_j(26'h100);
      mem[256] = enc_j(26'h4);
      mem[4]   = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
      release_reset();
      wait_ret(9, ok);
      total++;
      if (!ok) $display("FAIL br_timeout: got %0d retires want 9",
                        q_pc.size());
      else passed++;
      for (int i = 0; i < 9; i++) begin
         total++;
         if (q_pc[i] !== exp_pc[i])
            $display("FAIL br_pc%0d: got %h want %h", i,
                     q_pc[i], exp_pc[i]);
         else passed++;
      end
      total++;
      if (q_cy[4] - q_cy[3] != 3)
         $display("FAIL beq_nt_cpi: got %0d want 3", q_cy[4] - q_cy[3]);
      else passed++;
      total++;
      if (q_cy[6] - q_cy[5] != 2)
         $display("FAIL j_cpi: got %0d want 2", q_cy[6] - q_cy[5]);
      else passed++;
      total++;
      if (q_cy[8] - q_cy[7] != 3)
         $display("FAIL beq_t_cpi: got %0d want 3", q_cy[8] - q_cy[7]);
      else passed++;
   endtask

   task automatic test_zero_slt();
      bit ok;
      start_reset();
      mem[0] = enc_i(6'h08, 5'd0, 5'd6, 16'd33);
      mem[1] = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
      mem[2] = enc_r(5'd0, 5'd0, 5'd6, 6'h20);
      mem[3] = enc_i(6'h08, 5'd0, 5'd1, 16'hFFFF);
      mem[4] = enc_i(6'h08, 5'd0, 5'd2, 16'd1);
      mem[5] = enc_r(5'd1, 5'd2, 5'd7, 6'h2A);
      mem[6] = enc_r(5'd2, 5'd1, 5'd8, 6'h2A);
      mem[7] = enc_r(5'd1, 5'd2, 5'd9, 6'h24);
      mem[8] = enc_j(26'd8);
      release_reset();
      wait_ret(8, ok);
      total++;
      if (!ok) $display("FAIL zs_timeout: got %0d retires want 8",
                        q_pc.size());
      else passed++;
      total++;
      if (dut.regs[0] !== 32'd0 || dut.regs[6] !== 32'd0)
         $display("FAIL reg_zero: got r0 %h r6 %h want 0 0",
                  dut.regs[0], dut.regs[6]);
      else passed++;
      total++;
      if (dut.regs[1] !== 32'hFFFF_FFFF)
         $display("FAIL addi_sext: got %h want ffffffff", dut.regs[1]);
      else passed++;
      total++;
      if (dut.regs[7] !== 32'd1 || dut.regs[8] !== 32'd0)
         $display("FAIL slt_signed: got r7 %h r8 %h want 1 0",
                  dut.regs[7], dut.regs[8]);
      else passed++;
      total++;
      if (dut.regs[9] !== 32'd1)
         $display("FAIL and_r9: got %h want 1", dut.regs[9]);
      else passed++;
   endtask

   task automatic test_misaligned();
      bit ok;
      int reqc;
      start_reset();
      mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
      mem[1] = enc_i(6'h23, 5'd0, 5'd7, 16'd2);
      release_reset();
      wait_ret(1, ok);
      reqc = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (mem_req) reqc++;
      end
      total++;
      if (!ok || trapped !== 1'b1)
         $display("FAIL misalign_trap: got ok %b trapped %b want 1 1",
                  ok, trapped);
      else passed++;
      total++;
      if (reqc != 0 || q_pc.size() != 1)
         $display("FAIL misalign_noreq: got %0d reqs %0d retires want 0 1",
                  reqc, q_pc.size());
      else passed++;
      total++;
      if (dut.regs[7] !== 32'd0)
         $display("FAIL misalign_r7: got %h want 0", dut.regs[7]);
      else passed++;
   endtask

   task automatic test_illegal();
      bit ok;
      start_reset();
      mem[0] = 32'hFC00_0000;
      mem[1] = enc_i(6'h08, 5'd0, 5'd9, 16'd77);
      mem[2] = enc_j(26'd2);
      release_reset();
      repeat (10) @(negedge clk);
      total++;
      if (trapped !== 1'b1 || mem_req !== 1'b0 || q_pc.size() != 0)
         $display("FAIL illegal_trap: got t %b req %b ret %0d want 1 0 0",
                  trapped, mem_req, q_pc.size());
      else passed++;
      q2_pc.delete(); q2_in.delete(); q2_cy.delete();
      @(negedge clk);
      rst2_n = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         #1;
         if (q2_pc.size() >= 2) begin
            ok = 1'b1;
            break;
         end
      end
      total++;
      if (!ok) $display("FAIL nop_timeout: got %0d retires want 2",
                        q2_pc.size());
      else passed++;
      total++;
      if (q2_pc[0] !== 32'h0 || q2_in[0] !== 32'hFC00_0000)
         $display("FAIL nop_retire: got %h/%h want 0/fc000000",
                  q2_pc[0], q2_in[0]);
      else passed++;
      total++;
      if (q2_pc[1] !== 32'h4 || q2_cy[1] - q2_cy[0] != 4)
         $display("FAIL nop_next: got pc %h lat %0d want 4 4",
                  q2_pc[1], q2_cy[1] - q2_cy[0]);
      else passed++;
      total++;
      if (trapped2 !== 1'b0 || dut_nt.regs[9] !== 32'd77)
         $display("FAIL nop_state: got t %b r9 %h want 0 4d",
                  trapped2, dut_nt.regs[9]);
      else passed++;
      @(negedge clk);
      rst2_n = 1'b0;
   endtask

   task automatic test_async_reset();
      bit found, seen;
      start_reset();
      mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
      mem[1] = enc_j(26'd1);
      wait_n = 5;
      release_reset();
      found = 1'b0;
      for (int k = 0; k < 60 && !found; k++) begin
         @(negedge clk);
         if (mem_req && mem_addr === 32'h4) found = 1'b1;
      end
      #1;
      rst_n = 1'b0;
      #1;
      total++;
      if (!found || mem_req !== 1'b0 || mem_we !== 1'b0 ||
          trapped !== 1'b0 || retire_valid !== 1'b0)
         $display("FAIL async_flags: found %b req %b we %b t %b rv %b",
                  found, mem_req, mem_we, trapped, retire_valid);
      else passed++;
      total++;
      if (mem_addr !== 32'd0 || mem_wdata !== 32'd0 ||
          retire_pc !== 32'd0 || retire_instr !== 32'd0)
         $display("FAIL async_values: got %h %h %h %h want all 0",
                  mem_addr, mem_wdata, retire_pc, retire_instr);
      else passed++;
      total++;
      if (dut.regs[1] !== 32'd0)
         $display("FAIL async_regs: got r1 %h want 0", dut.regs[1]);
      else passed++;
      wait_n = 0;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 5 && !seen; k++) begin
         @(negedge clk);
         if (mem_req) seen = 1'b1;
      end
      total++;
      if (!seen || mem_addr !== 32'd0 || mem_we !== 1'b0)
         $display("FAIL async_refetch: req %b addr %h we %b want 1 0 0",
                  seen, mem_addr, mem_we);
      else passed++;
   endtask

   initial begin
      rst_n = 1'b0;
      test_reset();
      test_alu_program();
      test_mem_wait();
      test_branch_jump();
      test_zero_slt();
      test_misaligned();
      test_illegal();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
